// File: rtl/sd_scoreboard_pkg.sv
// Request type encodings shared between the scoreboard initiator and the scoreboard FSM.
package sd_scoreboard_pkg;
   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_type_e;
endpackage

// File: rtl/sd_scoreboard_rob.sv
// Reorder storage for outstanding reads: per-txid data slot, item tag and pend/rdy flags.
module sd_scoreboard_rob #(
   parameter int width   = 8,
   parameter int asz     = 6,
   parameter int txid_sz = 2,
   parameter int depth   = 2**txid_sz
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               alloc_en,
   input  logic [txid_sz-1:0] alloc_idx,
   input  logic [asz-1:0]     alloc_tag,
   input  logic               rsp_en,
   input  logic [txid_sz-1:0] rsp_idx,
   input  logic [width-1:0]   rsp_data,
   output logic               rsp_ok,
   input  logic               retire_en,
   input  logic [txid_sz-1:0] head_idx,
   output logic               head_rdy,
   output logic [width-1:0]   head_data,
   output logic [asz-1:0]     head_tag
);
   logic [depth-1:0] pend;
   logic [depth-1:0] rdy;
   logic [width-1:0] slot [depth];
   logic [asz-1:0]   tag  [depth];

   // Slot and tag contents are cleared too so the head read port shows zeros out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend <= '0;
         rdy  <= '0;
         for (int i = 0; i < depth; i++) begin
            slot[i] <= '0;
            tag[i]  <= '0;
         end
      end else begin
         if (retire_en) begin
            pend[head_idx] <= 1'b0;
            rdy[head_idx]  <= 1'b0;
         end
         if (alloc_en) begin
            pend[alloc_idx] <= 1'b1;
            tag[alloc_idx]  <= alloc_tag;
         end
         if (rsp_en) begin
            rdy[rsp_idx]  <= 1'b1;
            slot[rsp_idx] <= rsp_data;
         end
      end
   end

   assign rsp_ok    = pend[rsp_idx] & ~rdy[rsp_idx];
   assign head_rdy  = rdy[head_idx];
   assign head_data = slot[head_idx];
   assign head_tag  = tag[head_idx];
endmodule

// File: rtl/sd_scoreboard_initiator.sv
// Scoreboard initiator: issues read/write commands in order, tracks reads by txid and returns results in order.
module sd_scoreboard_initiator
   import sd_scoreboard_pkg::*;
#(
   parameter int width   = 8,
   parameter int items   = 64,
   parameter int txid_sz = 2,
   parameter int asz     = $clog2(items),
   parameter int depth   = 2**txid_sz
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               c_srdy,
   output logic               c_drdy,
   input  logic               c_req_type,
   input  logic [width-1:0]   c_mask,
   input  logic [width-1:0]   c_data,
   input  logic [asz-1:0]     c_itemid,
   output logic               sb_srdy,
   input  logic               sb_drdy,
   output logic               sb_req_type,
   output logic [txid_sz-1:0] sb_txid,
   output logic [width-1:0]   sb_mask,
   output logic [width-1:0]   sb_data,
   output logic [asz-1:0]     sb_itemid,
   input  logic               rsp_srdy,
   output logic               rsp_drdy,
   input  logic [txid_sz-1:0] rsp_txid,
   input  logic [width-1:0]   rsp_data,
   output logic               p_srdy,
   input  logic               p_drdy,
   output logic [width-1:0]   p_data,
   output logic [asz-1:0]     p_itemid,
   output logic               err
);
   localparam logic [txid_sz:0] depth_cnt = (txid_sz+1)'(depth);

   logic               req_v;
   req_type_e          req_type;
   logic [width-1:0]   req_mask;
   logic [width-1:0]   req_data;
   logic [asz-1:0]     req_itemid;
   logic [txid_sz-1:0] alloc_ptr;
   logic [txid_sz-1:0] ret_ptr;
   logic [txid_sz:0]   outstanding;
   logic               c_fire;
   logic               sb_fire;
   logic               alloc_en;
   logic               retire_en;
   logic               rsp_ok;
   logic               rsp_fire;
   logic               is_read;

   assign is_read   = (req_type == REQ_READ);
   assign sb_fire   = sb_srdy & sb_drdy;
   assign c_drdy    = ~req_v | sb_fire;
   assign c_fire    = c_srdy & c_drdy;
   assign alloc_en  = sb_fire & is_read;
   assign retire_en = p_srdy & p_drdy;
   assign rsp_fire  = rsp_srdy & rsp_ok;
   assign rsp_drdy  = 1'b1;

   // Registered count only: a retire frees a txid for the next cycle, not this one.
   assign sb_srdy     = req_v & (~is_read | (outstanding < depth_cnt));
   assign sb_req_type = req_type;
   assign sb_txid     = (req_v && is_read) ? alloc_ptr : '0;
   assign sb_mask     = !req_v ? '0 : (is_read ? '1 : req_mask);
   assign sb_data     = (req_v && !is_read) ? req_data : '0;
   assign sb_itemid   = req_itemid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         req_v      <= 1'b0;
         req_type   <= REQ_READ;
         req_mask   <= '0;
         req_data   <= '0;
         req_itemid <= '0;
      end else if (c_fire) begin
         req_v      <= 1'b1;
         req_type   <= req_type_e'(c_req_type);
         req_mask   <= c_mask;
         req_data   <= c_data;
         req_itemid <= c_itemid;
      end else if (sb_fire) begin
         req_v      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alloc_ptr   <= '0;
         ret_ptr     <= '0;
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         if (alloc_en)
            alloc_ptr <= alloc_ptr + 1'b1;
         if (retire_en)
            ret_ptr <= ret_ptr + 1'b1;
         case ({alloc_en, retire_en})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (rsp_srdy && !rsp_ok)
            err <= 1'b1;
      end
   end

   sd_scoreboard_rob #(
      .width   (width),
      .asz     (asz),
      .txid_sz (txid_sz),
      .depth   (depth)
   ) u_rob (
      .clk       (clk),
      .reset_n   (reset_n),
      .alloc_en  (alloc_en),
      .alloc_idx (alloc_ptr),
      .alloc_tag (req_itemid),
      .rsp_en    (rsp_fire),
      .rsp_idx   (rsp_txid),
      .rsp_data  (rsp_data),
      .rsp_ok    (rsp_ok),
      .retire_en (retire_en),
      .head_idx  (ret_ptr),
      .head_rdy  (p_srdy),
      .head_data (p_data),
      .head_tag  (p_itemid)
   );
endmodule

// File: doc/sd_scoreboard_initiator.md
SD_SCOREBOARD_INITIATOR -- requirements
Module: sd_scoreboard_initiator

Interface
REQ-001 Parameters SHALL be, one per line: width, 8, record width; items, 64, scoreboard entries; txid_sz, 2, txid bits; asz, $clog2(items), item address width; depth (derived), 2**txid_sz, maximum outstanding reads.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 c_srdy in 1, c_drdy out 1: upstream command handshake.
REQ-005 c_req_type in 1 (0=read, 1=write); c_mask in width; c_data in width; c_itemid in asz.
REQ-006 sb_srdy out 1, sb_drdy in 1: request to scoreboard.
REQ-007 sb_req_type out 1; sb_txid out txid_sz; sb_mask out width; sb_data out width; sb_itemid out asz.
REQ-008 rsp_srdy in 1, rsp_drdy out 1, rsp_txid in txid_sz, rsp_data in width: read response from scoreboard.
REQ-009 p_srdy out 1, p_drdy in 1, p_data out width, p_itemid out asz: in-order read results to downstream.
REQ-010 err out 1: sticky flag for an unexpected response.

Function
REQ-011 A one-entry request holding register (req_v) SHALL capture c_* on c_srdy&c_drdy.
REQ-012 c_drdy SHALL equal !req_v | (sb_srdy&sb_drdy), giving full throughput with no bubble.
REQ-013 sb_srdy SHALL equal req_v & (req_type==1 | outstanding<depth); sb_* SHALL be driven from the holding register; command to sb_srdy latency is 1 cycle.
REQ-014 Requests SHALL issue strictly in acceptance order; a read stalled at the head for lack of a txid SHALL also block any write behind it.
REQ-015 Writes SHALL pass mask and data unchanged, allocate no txid, expect no response, and drive sb_txid=0.
REQ-016 On a read handshake, sb_txid SHALL equal alloc_ptr; itemid SHALL be stored in tag[alloc_ptr]; pend[alloc_ptr] SHALL be set; alloc_ptr SHALL increment modulo depth; outstanding SHALL increment.
REQ-017 Read requests SHALL drive sb_mask all ones and sb_data=0.
REQ-018 rsp_drdy SHALL be constantly 1, because every accepted read owns a reserved slot.
REQ-019 On rsp_srdy with pend[rsp_txid]=1 and rdy[rsp_txid]=0, rsp_data SHALL be written to slot[rsp_txid] and rdy[rsp_txid] set.
REQ-020 Any other response (slot not pending, or already filled) SHALL be dropped, set err, and leave slot state unchanged.
REQ-021 p_srdy SHALL equal rdy[ret_ptr]; p_data SHALL be slot[ret_ptr]; p_itemid SHALL be tag[ret_ptr]; response-to-p_srdy latency is 1 cycle when the slot is at the head.
REQ-022 On p_srdy&p_drdy: pend and rdy of ret_ptr SHALL clear; ret_ptr SHALL increment modulo depth; outstanding SHALL decrement.
REQ-023 A read allocation and a retire in the same cycle SHALL leave outstanding unchanged; outstanding SHALL be txid_sz+1 bits, range 0..depth.
REQ-024 When outstanding==depth and a retire occurs in the same cycle, the head read SHALL still wait one cycle, because sb_srdy uses the registered count.
REQ-025 A response for slot X arriving while slot ret_ptr retires SHALL both complete in that cycle.

Reset
REQ-026 While reset_n=0, asynchronously: req_v, pend, rdy, alloc_ptr, ret_ptr, outstanding and err SHALL be 0, and slot/tag contents SHALL be don't-care.
REQ-027 Output values during and after reset SHALL be: c_drdy=1, sb_srdy=0, p_srdy=0, rsp_drdy=1, err=0, and all data outputs 0.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding reads; responses arriving after reset release SHALL set err.

Structure
REQ-029 The shared package sd_scoreboard_pkg SHALL hold the request type encodings (REQ_READ=0, REQ_WRITE=1), shared with the scoreboard FSM.
REQ-030 Slot data, tag and rdy/pend storage SHALL live in one sub-module, sd_scoreboard_rob, with one write port per side (allocate, response) and one combinational read port (head).

Verification
REQ-031 Single write, itemid=5, data=0xA5, mask=0xFF -> one sb beat (type 1, txid 0, data 0xA5), no p_srdy, err=0.
REQ-032 Four reads, itemids 1..4, depth=4, scoreboard never responds -> txids 0,1,2,3 issued; a fifth command holds sb_srdy=0 until one result retires.
REQ-033 Responses returned in order txid 2,0,3,1 with data 0x22,0x00,0x33,0x11 -> p_* emits itemid 1,2,3,4 in that order with data 0x00,0x11,0x22,0x33.
REQ-034 p_drdy=0 for 10 cycles with 4 reads outstanding -> p_data stable, no loss; the full-count stall is held and released one cycle after the first retire.
REQ-035 Response with rsp_txid=3 when no read is pending -> err=1 and sticky; p_srdy stays 0.
REQ-036 reset_n pulsed low with 2 reads outstanding -> outputs take reset values immediately; a subsequent rsp_txid=0 sets err=1.
